hs_fifo: RTL and testbench
==========================

HS_FIFO -- requirements
Module: hs_fifo

Interface
REQ-001 SHALL have parameter: width, 4, payload width in bits.
REQ-002 SHALL have parameter: depth, 4, entry count; power of two, minimum 2.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: valid_up  input  1  upstream word valid.
REQ-006 SHALL have port: ready_up  output  1  FIFO can accept a word.
REQ-007 SHALL have port: data_up  input  [0:width-1]  upstream payload.
REQ-008 SHALL have port: valid_down  output  1  word available downstream.
REQ-009 SHALL have port: ready_down  input  1  downstream accepts a word.
REQ-010 SHALL have port: data_down  output  [0:width-1]  downstream payload.
REQ-011 SHALL have port: count  output  clog2(depth)+1  current number of stored words.

Function
REQ-012 SHALL sit directly downstream of the ready-registered skid stage, absorbing its output stream.
REQ-013 SHALL push when valid_up && ready_up: write data_up at the write pointer, advance the write pointer.
REQ-014 SHALL pop when valid_down && ready_down: advance the read pointer; the word is consumed.
REQ-015 SHALL use read/write pointers of clog2(depth)+1 bits; full = MSBs differ and LSBs equal; empty = pointers equal; wrap-around is modulo 2*depth.
REQ-016 SHALL drive ready_up = ~full, ready_up independent of ready_down (no same-cycle pass-through when full).
REQ-017 SHALL drive valid_down = ~empty and data_down = entry at the read pointer (non-bypass path).
REQ-018 SHALL update count by +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on idle.
REQ-019 SHALL accept a simultaneous push and pop when neither full nor empty, with count unchanged.
REQ-020 SHALL keep data_down stable while valid_down && ~ready_down.
REQ-021 SHALL never overflow or underflow; a push is impossible while full and a pop is impossible while empty.
REQ-022 SHALL have a push-to-valid_down latency of 1 cycle when empty and the bypass is absent.
REQ-023 SHALL preserve strict FIFO order across pointer wrap-around.

Reset
REQ-024 SHALL, on rst low, asynchronously clear both pointers and count, forcing ready_up=1, valid_down=0, count=0.
REQ-025 SHALL, on reset mid-operation, discard all stored words; storage array contents are not reset and are don't-care.
REQ-026 SHALL resume normal operation on the first posedge clk after rst deasserts.

Configuration
REQ-027 SHALL compile a zero-latency bypass when macro HS_FIFO_BYPASS_EN is defined.
REQ-028 SHALL, with HS_FIFO_BYPASS_EN defined and the FIFO empty, drive valid_down=valid_up and data_down=data_up combinationally.
REQ-029 SHALL, with HS_FIFO_BYPASS_EN defined, not write a word that is accepted downstream in the same bypass cycle, leaving pointers and count unchanged.
REQ-030 SHALL, with HS_FIFO_BYPASS_EN defined and the FIFO empty but ready_down low, store the word normally.
REQ-031 SHALL, without HS_FIFO_BYPASS_EN, route every word through storage with the 1-cycle latency of REQ-022.

Verification (width=4, depth=4)
REQ-032 SHALL cover reset: assert rst low mid-stream with count=3 -> count=0, valid_down=0, ready_up=1 immediately, before any clock edge.
REQ-033 SHALL cover fill: hold ready_down=0 and push 0x1,0x2,0x3,0x4 -> count=4, ready_up=0; a 5th word 0x5 is held off until the first pop.
REQ-034 SHALL cover drain: from full, ready_down=1 for 4 cycles -> data_down 0x1,0x2,0x3,0x4 in order, then valid_down=0, count=0.
REQ-035 SHALL cover wrap-around: 10 words 0x0..0x9 streamed with random ready_down -> output order 0x0..0x9 and count never exceeds 4.
REQ-036 SHALL cover simultaneous push and pop at count=2 -> count stays 2 and the oldest word is output.
REQ-037 SHALL cover bypass: empty, valid_up=1 with data_up=0xA, ready_down=1 -> with HS_FIFO_BYPASS_EN data_down=0xA in the same cycle and count=0; without it, valid_down=1 with data_down=0xA one cycle later.

Source files
------------

// File: rtl/hs_fifo.sv
// Ready/valid FIFO with pointer-based full/empty detection and an occupancy count.
// Optional zero-latency empty bypass, compiled in when HS_FIFO_BYPASS_EN is defined.
module hs_fifo #(
  parameter int unsigned width = 4,
  parameter int unsigned depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_up,
  output logic                       ready_up,
  input  logic [0:width-1]           data_up,
  output logic                       valid_down,
  input  logic                       ready_down,
  output logic [0:width-1]           data_down,
  output logic [$clog2(depth):0]     count
);

  localparam int unsigned AddrW = $clog2(depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [0:width-1] mem_q [depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  count_q, count_d;
  logic             full, empty;
  logic             push, pop;

  // Extra MSB on each pointer separates the full and empty cases when the index bits match.
  assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign ready_up = ~full;
  assign count    = count_q;

`ifdef HS_FIFO_BYPASS_EN
  logic bypass;

  // An empty FIFO forwards the upstream word; it is stored only if downstream stalls.
  assign bypass     = empty && valid_up && ready_down;
  assign valid_down = ~empty | valid_up;
  assign data_down  = empty ? data_up : mem_q[rd_ptr_q[AddrW-1:0]];
  assign push       = valid_up && ready_up && ~bypass;
  assign pop        = ~empty && ready_down;
`else
  assign valid_down = ~empty;
  assign data_down  = mem_q[rd_ptr_q[AddrW-1:0]];
  assign push       = valid_up && ready_up;
  assign pop        = valid_down && ready_down;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + PtrW'(1);
      2'b01:   count_d = count_q - PtrW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= data_up;
    end
  end

endmodule

// File: tb/tb_hs_fifo.sv
// Scoreboard bench for hs_fifo (width=4, depth=4): the driver queues expected words,
// a monitor pops and compares on every downstream handshake.
module tb_hs_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_up;
  logic       ready_up;
  logic [0:3] data_up;
  logic       valid_down;
  logic       ready_down;
  logic [0:3] data_down;
  logic [2:0] count;

  int         checks = 0;
  int         errors = 0;
  logic [0:3] sb[$];

  hs_fifo #(.width(4), .depth(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_up   (valid_up),
    .ready_up   (ready_up),
    .data_up    (data_up),
    .valid_down (valid_down),
    .ready_down (ready_down),
    .data_down  (data_down),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Holds the word until ready_up is seen mid-cycle, then records it as expected output.
  task automatic push_word(input logic [0:3] d);
    int n = 0;
    valid_up = 1'b1;
    data_up  = d;
    forever begin
      @(negedge clk);
      if (ready_up) begin
        sb.push_back(d);
        break;
      end
      n++;
      if (n > 50) begin
        chk("push_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk); #1;
      ready_down = 1'b1;
    end
    @(posedge clk); #1;
    valid_up = 1'b0;
  endtask

  // Monitor: order check on handshakes, stability under stall, occupancy bound.
  initial begin
    logic       stall_q = 1'b0;
    logic [0:3] stall_data = '0;
    logic [0:3] exp;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) chk("stall_stable", 32'(data_down), 32'(stall_data));
        chk("count_bound", 32'(count <= 3'd4), 32'd1);
        if (valid_down && ready_down) begin
          if (sb.size() == 0) begin
            chk("unexpected_word", 32'(data_down), 32'hFFFF);
          end else begin
            exp = sb.pop_front();
            chk("data_order", 32'(data_down), 32'(exp));
          end
        end
        stall_q    = valid_down && !ready_down;
        stall_data = data_down;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst        = 1'b0;
    valid_up   = 1'b0;
    ready_down = 1'b0;
    data_up    = '0;
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid_down", 32'(valid_down), 32'd0);
    chk("rst_ready_up", 32'(ready_up), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Fill to full, fifth word held off until one pop.
    push_word(4'h1); push_word(4'h2); push_word(4'h3); push_word(4'h4);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ready_up", 32'(ready_up), 32'd0);
    valid_up = 1'b1;
    data_up  = 4'h5;
    repeat (2) @(posedge clk); #1;
    chk("held_count", 32'(count), 32'd4);
    chk("held_ready_up", 32'(ready_up), 32'd0);
    ready_down = 1'b1;
    @(posedge clk); #1;
    ready_down = 1'b0;
    chk("one_pop_count", 32'(count), 32'd3);
    chk("one_pop_ready_up", 32'(ready_up), 32'd1);
    sb.push_back(4'h5);
    @(posedge clk); #1;
    valid_up = 1'b0;
    chk("refill_count", 32'(count), 32'd4);

    // Drain from full.
    ready_down = 1'b1;
    repeat (4) @(posedge clk); #1;
    ready_down = 1'b0;
    chk("drain_valid_down", 32'(valid_down), 32'd0);
    chk("drain_count", 32'(count), 32'd0);

    // Simultaneous push and pop at count=2.
    push_word(4'h6); push_word(4'h7);
    chk("pre_simul_count", 32'(count), 32'd2);
    valid_up   = 1'b1;
    data_up    = 4'h8;
    ready_down = 1'b1;
    sb.push_back(4'h8);
    @(posedge clk); #1;
    valid_up = 1'b0;
    chk("simul_count", 32'(count), 32'd2);
    chk("simul_next_head", 32'(data_down), 32'h7);
    repeat (2) @(posedge clk); #1;
    ready_down = 1'b0;
    chk("simul_drain_count", 32'(count), 32'd0);

    // Empty FIFO, downstream ready: bypass versus one-cycle storage latency.
    valid_up   = 1'b1;
    data_up    = 4'hA;
    ready_down = 1'b1;
    sb.push_back(4'hA);
    #1;
`ifdef HS_FIFO_BYPASS_EN
    chk("bypass_valid", 32'(valid_down), 32'd1);
    chk("bypass_data", 32'(data_down), 32'hA);
    @(posedge clk); #1;
    valid_up = 1'b0;
    #1;
    chk("bypass_count", 32'(count), 32'd0);
    chk("bypass_after_valid", 32'(valid_down), 32'd0);
`else
    chk("nobypass_valid_early", 32'(valid_down), 32'd0);
    @(posedge clk); #1;
    valid_up = 1'b0;
    #1;
    chk("nobypass_valid", 32'(valid_down), 32'd1);
    chk("nobypass_data", 32'(data_down), 32'hA);
    @(posedge clk); #1;
    chk("nobypass_count", 32'(count), 32'd0);
`endif
    ready_down = 1'b0;

    // Wrap-around stream with random downstream readiness.
    for (int i = 0; i < 10; i++) begin
      ready_down = 1'($urandom_range(0, 1));
      push_word(4'(i));
    end
    ready_down = 1'b1;
    n = 0;
    while (count != 3'd0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wrap_drained", 32'(count), 32'd0);
    chk("wrap_valid_down", 32'(valid_down), 32'd0);
    ready_down = 1'b0;

    // Asynchronous reset mid-stream with three words stored.
    push_word(4'h1); push_word(4'h2); push_word(4'h3);
    chk("pre_rst_count", 32'(count), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_valid_down", 32'(valid_down), 32'd0);
    chk("async_rst_ready_up", 32'(ready_up), 32'd1);
    sb.delete();
    #3 rst = 1'b1;
    @(posedge clk); #1;

    // Normal operation resumes after reset.
    push_word(4'hC);
    chk("resume_count", 32'(count), 32'd1);
    chk("resume_data", 32'(data_down), 32'hC);
    ready_down = 1'b1;
    @(posedge clk); #1;
    ready_down = 1'b0;
    chk("resume_drain_count", 32'(count), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
